// File: rtl/pmu_quota_pkg.sv
// Shared sizing helpers for the multi-core PMU quota monitor.
package pmu_quota_pkg;

    // Accumulator width: wide enough to hold the sum of every counter without wrapping.
    function automatic int sum_width_f(input int reg_width, input int n_counters);
        return reg_width + $clog2(n_counters);
    endfunction

    // Width of the shared scan index.
    function automatic int idx_width_f(input int n_counters);
        return $clog2(n_counters);
    endfunction

endpackage

// File: rtl/pmu_quota_chan.sv
// One quota channel: accumulates the masked counters of a sweep, publishes the
// total on clean sweeps and keeps the sticky quota-exceeded interrupt.
module pmu_quota_chan
    import pmu_quota_pkg::*;
#(
    parameter int REG_WIDTH  = 32,
    parameter int N_COUNTERS = 9,
    localparam int SUM_WIDTH = sum_width_f(REG_WIDTH, N_COUNTERS),
    localparam int IDX_W     = idx_width_f(N_COUNTERS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic                  first_i,
    input  logic                  last_i,
    input  logic [REG_WIDTH-1:0]  value_i,
    input  logic [N_COUNTERS-1:0] mask_i,
    input  logic [SUM_WIDTH-1:0]  limit_i,
    input  logic                  clear_i,
    output logic [SUM_WIDTH-1:0]  sum_o,
    output logic                  valid_o,
    output logic                  intr_o
);

    logic [SUM_WIDTH-1:0]  acc_q, acc_d;
    logic [N_COUNTERS-1:0] old_mask_q, old_mask_d;
    logic                  dirty_q, dirty_d;
    logic [SUM_WIDTH-1:0]  sum_q, sum_d;
    logic                  valid_q, valid_d;
    logic                  intr_q, intr_d;

    logic [SUM_WIDTH-1:0]  term;
    logic [SUM_WIDTH-1:0]  acc_sum;
    logic                  mask_chg;
    logic                  publish;

    // Accumulate, track mask stability and decide whether this sweep publishes.
    always_comb begin
        mask_chg   = (mask_i != old_mask_q);
        term       = mask_i[idx_i] ? SUM_WIDTH'(value_i) : '0;
        acc_sum    = acc_q + term;
        acc_d      = first_i ? term : acc_sum;
        old_mask_d = mask_i;
        // A change on the wrap cycle itself keeps the next sweep dirty as well.
        dirty_d    = last_i ? mask_chg : (dirty_q | mask_chg);
        publish    = last_i && !dirty_q && !mask_chg;
        sum_d      = publish ? acc_sum : sum_q;
        valid_d    = publish;
        // Set has priority over a simultaneous clear.
        intr_d     = (intr_q && !clear_i) || (publish && (acc_sum > limit_i));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q      <= '0;
            old_mask_q <= '0;
            dirty_q    <= 1'b0;
            sum_q      <= '0;
            valid_q    <= 1'b0;
            intr_q     <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            old_mask_q <= old_mask_d;
            dirty_q    <= dirty_d;
            sum_q      <= sum_d;
            valid_q    <= valid_d;
            intr_q     <= intr_d;
        end
    end

    assign sum_o   = sum_q;
    assign valid_o = valid_q;
    assign intr_o  = intr_q;

endmodule

// File: rtl/pmu_quota_mc.sv
// Multi-core quota monitor: one shared scan index and counter mux feeding
// N_CORES independent quota channels.
module pmu_quota_mc
    import pmu_quota_pkg::*;
#(
    parameter int REG_WIDTH  = 32,
    parameter int N_COUNTERS = 9,
    parameter int N_CORES    = 4,
    localparam int SUM_WIDTH = sum_width_f(REG_WIDTH, N_COUNTERS)
) (
    input  logic                                    clk_i,
    input  logic                                    rstn_i,
    input  logic                                    softrst_i,
    input  logic [N_COUNTERS-1:0][REG_WIDTH-1:0]    counter_value_i,
    input  logic [N_CORES-1:0][N_COUNTERS-1:0]      quota_mask_i,
    input  logic [N_CORES-1:0][SUM_WIDTH-1:0]       quota_limit_i,
    input  logic [N_CORES-1:0]                      intr_clear_i,
    output logic [N_CORES-1:0][SUM_WIDTH-1:0]       quota_sum_o,
    output logic [N_CORES-1:0]                      sum_valid_o,
    output logic [N_CORES-1:0]                      intr_quota_o
);

    localparam int IDX_W = idx_width_f(N_COUNTERS);

    logic                 rst;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 first, last;
    logic [REG_WIDTH-1:0] sel_value;

    assign rst = !rstn_i || softrst_i;

    // Scan index: 0 .. N_COUNTERS-1, then wrap.
    always_comb begin
        first = (idx_q == '0);
        last  = (idx_q == IDX_W'(N_COUNTERS - 1));
        idx_d = last ? '0 : idx_q + 1'b1;
    end

    // Scan index register.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Single counter mux shared by every channel.
    always_comb begin
        sel_value = '0;
        for (int k = 0; k < N_COUNTERS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_value = counter_value_i[k];
            end
        end
    end

    for (genvar c = 0; c < N_CORES; c++) begin : g_chan
        pmu_quota_chan #(
            .REG_WIDTH  (REG_WIDTH),
            .N_COUNTERS (N_COUNTERS)
        ) u_chan (
            .clk_i   (clk_i),
            .rst_i   (rst),
            .idx_i   (idx_q),
            .first_i (first),
            .last_i  (last),
            .value_i (sel_value),
            .mask_i  (quota_mask_i[c]),
            .limit_i (quota_limit_i[c]),
            .clear_i (intr_clear_i[c]),
            .sum_o   (quota_sum_o[c]),
            .valid_o (sum_valid_o[c]),
            .intr_o  (intr_quota_o[c])
        );
    end

endmodule

// File: tb/tb_pmu_quota_mc.sv
// Self-checking bench for pmu_quota_mc: directed scenarios plus randomized
// traffic, with a sweep-level reference model feeding a publish scoreboard.
module tb_pmu_quota_mc;

    localparam int RW = 32;
    localparam int N  = 9;
    localparam int C  = 2;
    localparam int SW = RW + $clog2(N);

    logic                      clk = 1'b0;
    logic                      rstn;
    logic                      softrst;
    logic [N-1:0][RW-1:0]      cnt;
    logic [C-1:0][N-1:0]       mask;
    logic [C-1:0][SW-1:0]      lim;
    logic [C-1:0]              clr;
    logic [C-1:0][SW-1:0]      qsum;
    logic [C-1:0]              sv;
    logic [C-1:0]              intr;

    pmu_quota_mc #(
        .REG_WIDTH  (RW),
        .N_COUNTERS (N),
        .N_CORES    (C)
    ) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .softrst_i       (softrst),
        .counter_value_i (cnt),
        .quota_mask_i    (mask),
        .quota_limit_i   (lim),
        .intr_clear_i    (clr),
        .quota_sum_o     (qsum),
        .sum_valid_o     (sv),
        .intr_quota_o    (intr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int              cyc;
        int              core;
        logic [SW-1:0]   sum;
    } pub_t;

    pub_t          scb[$];
    int            cyc = 0;
    int            m_pos = 0;
    bit            mon_en = 0;
    logic [N-1:0]  prev_mask [C];
    bit            sdirty [C];
    logic [SW-1:0] contrib [C][N];
    logic [SW-1:0] m_sum [C];
    bit            m_intr [C];

    // Sweep-level model: logs each core's masked contribution per scan slot and
    // at sweep end sums the log; any mask change during the sweep spoils it.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rstn || softrst) begin
                m_pos  = 0;
                mon_en = 1;
                for (int c = 0; c < C; c++) begin
                    prev_mask[c] = '0;
                    sdirty[c]    = 0;
                    m_sum[c]     = '0;
                    m_intr[c]    = 0;
                end
            end else begin
                for (int c = 0; c < C; c++) begin
                    bit            chg;
                    bit            pub;
                    logic [SW-1:0] total;
                    chg          = (mask[c] != prev_mask[c]);
                    prev_mask[c] = mask[c];
                    contrib[c][m_pos] = mask[c][m_pos] ? SW'(cnt[m_pos]) : '0;
                    if (chg) sdirty[c] = 1;
                    pub   = 0;
                    total = '0;
                    if (m_pos == N - 1) begin
                        for (int k = 0; k < N; k++) total += contrib[c][k];
                        pub       = !sdirty[c];
                        sdirty[c] = chg;
                        if (pub) begin
                            m_sum[c] = total;
                            scb.push_back('{cyc, c, total});
                        end
                    end
                    m_intr[c] = (m_intr[c] && !clr[c]) || (pub && (total > lim[c]));
                end
                m_pos = (m_pos == N - 1) ? 0 : m_pos + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            bit            exp_v [C];
            logic [SW-1:0] exp_s [C];
            @(negedge clk);
            if (mon_en) begin
                for (int c = 0; c < C; c++) begin
                    exp_v[c] = 0;
                    exp_s[c] = '0;
                end
                while (scb.size() > 0 && scb[0].cyc <= cyc) begin
                    pub_t e;
                    e = scb.pop_front();
                    if (e.cyc < cyc) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL missed_publish: core %0d cycle %0d never seen", e.core, e.cyc);
                    end else begin
                        exp_v[e.core] = 1;
                        exp_s[e.core] = e.sum;
                    end
                end
                for (int c = 0; c < C; c++) begin
                    check($sformatf("sum_valid[%0d]", c), 64'(sv[c]), 64'(exp_v[c]));
                    if (sv[c] && exp_v[c])
                        check($sformatf("published_sum[%0d]", c), 64'(qsum[c]), 64'(exp_s[c]));
                    check($sformatf("held_sum[%0d]", c), 64'(qsum[c]), 64'(m_sum[c]));
                    check($sformatf("intr[%0d]", c), 64'(intr[c]), 64'(m_intr[c]));
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_pos(input int k);
        int guard;
        guard = 0;
        @(negedge clk);
        while (m_pos != k) begin
            guard++;
            if (guard > 3 * N) begin
                n_cmp++;
                n_err++;
                $display("FAIL wait_pos: scan slot %0d not reached", k);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic edge_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rstn    = 1'b0;
        softrst = 1'b0;
        for (int k = 0; k < N; k++) cnt[k] = 32'd10;
        mask[0] = 9'h1FF;
        mask[1] = 9'h001;
        lim[0]  = SW'(85);
        lim[1]  = SW'(5);
        clr     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sum0", 64'(qsum[0]), 64'd0);
        check("reset_valid", 64'(sv), 64'd0);
        check("reset_intr", 64'(intr), 64'd0);

        // Masks present at release: first sweep dirty, first publish at edge 2N.
        @(negedge clk);
        rstn = 1'b1;
        for (int e = 1; e <= 2 * N; e++) begin
            edge_check();
            if (e == N) check("no_publish_dirty_first_sweep", 64'(sv), 64'd0);
        end
        check("first_pub_valid", 64'(sv), 64'h3);
        check("first_pub_sum0", 64'(qsum[0]), 64'd90);
        check("first_pub_sum1", 64'(qsum[1]), 64'd10);
        check("first_pub_intr", 64'(intr), 64'h3);
        edge_check();
        check("valid_one_cycle", 64'(sv), 64'd0);

        // Equal-to-limit does not trip; clear drops interrupts.
        wait_pos(2);
        lim[0] = SW'(90);
        lim[1] = SW'(100);
        clr    = 2'b11;
        edge_check();
        check("clear_drops_intr", 64'(intr), 64'd0);
        @(negedge clk);
        clr = '0;
        wait_pos(N - 1);
        edge_check();
        check("sum_eq_limit_sum", 64'(qsum[0]), 64'd90);
        check("sum_eq_limit_intr", 64'(intr), 64'd0);
        wait_pos(0);
        cnt[3] = 32'd11;
        wait_pos(N - 1);
        edge_check();
        check("over_by_one_sum", 64'(qsum[0]), 64'd91);
        check("over_by_one_intr", 64'(intr), 64'h1);

        // Mask change mid-sweep suppresses only that core's publish.
        wait_pos(4);
        mask[0] = 9'h0FF;
        wait_pos(N - 1);
        edge_check();
        check("dirty_sweep_valid", 64'(sv), 64'h2);
        check("dirty_sweep_sum0_held", 64'(qsum[0]), 64'd91);
        check("dirty_sweep_sum1", 64'(qsum[1]), 64'd10);
        wait_pos(N - 1);
        edge_check();
        check("after_dirty_valid", 64'(sv), 64'h3);
        check("after_dirty_sum0", 64'(qsum[0]), 64'd81);

        // Set wins over simultaneous clear; a lone clear drops the interrupt.
        wait_pos(0);
        lim[0] = SW'(50);
        wait_pos(N - 1);
        clr = 2'b01;
        edge_check();
        check("set_beats_clear", 64'(intr), 64'h1);
        @(negedge clk);
        clr    = '0;
        lim[0] = SW'(100);
        wait_pos(3);
        clr = 2'b01;
        edge_check();
        check("clear_under_limit", 64'(intr), 64'd0);
        @(negedge clk);
        clr = '0;

        // Soft reset mid-sweep.
        wait_pos(5);
        softrst = 1'b1;
        edge_check();
        check("softrst_sum0", 64'(qsum[0]), 64'd0);
        check("softrst_sum1", 64'(qsum[1]), 64'd0);
        check("softrst_valid", 64'(sv), 64'd0);
        check("softrst_intr", 64'(intr), 64'd0);
        @(negedge clk);
        softrst = 1'b0;
        for (int e = 1; e <= 2 * N; e++) begin
            edge_check();
            if (e == N) check("softrst_first_sweep_dirty", 64'(sv), 64'd0);
        end
        check("softrst_pub_valid", 64'(sv), 64'h3);
        check("softrst_pub_sum0", 64'(qsum[0]), 64'd81);

        // Full-scale counters: no wrap in the accumulator.
        @(negedge clk);
        for (int k = 0; k < N; k++) cnt[k] = '1;
        mask[0] = 9'h1FF;
        mask[1] = 9'h1FF;
        lim[0]  = {SW{1'b1}};
        lim[1]  = SW'(64'h7_FFFF_FFFF);
        wait_pos(N - 1);
        edge_check();
        check("max_dirty_valid", 64'(sv), 64'd0);
        wait_pos(N - 1);
        edge_check();
        check("max_valid", 64'(sv), 64'h3);
        check("max_sum0", 64'(qsum[0]), 64'h8_FFFF_FFF7);
        check("max_intr", 64'(intr), 64'h2);

        // Randomized traffic, checked by the model and scoreboard.
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            rstn    = ($urandom_range(0, 299) != 0);
            softrst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < N; k++)
                cnt[k] = ($urandom_range(0, 15) == 0) ? '1 : RW'($urandom_range(0, 1000));
            for (int c = 0; c < C; c++) begin
                if ($urandom_range(0, 19) == 0) mask[c] = N'($urandom);
                if ($urandom_range(0, 29) == 0) lim[c] = SW'($urandom_range(0, 9000));
                clr[c] = ($urandom_range(0, 9) == 0);
            end
        end

        @(negedge clk);
        rstn    = 1'b1;
        softrst = 1'b0;
        clr     = '0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(scb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
